data_hazard_scoreboard: RTL and testbench
=========================================

# data_hazard_scoreboard

Scoreboard that sits directly downstream of the decode control reduction stage. It consumes the per-instruction hazard descriptor: source/destination GPR indices, read/write flags for GPRs, CTR, LNK, CR and XER. It tracks every in-flight write with a per-resource countdown and drives the decode `hold` that freezes fetch/decode until all read-after-write (RAW) and write-after-write (WAW) conflicts have retired.

## Interface
Parameters:
- `ALU_LAT`, 2, cycles from issue until an ALU-path write is visible in the register file (1..7)
- `MEM_LAT`, 4, cycles from issue until a load-path write is visible (`ALU_LAT`..15)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `valid`  in  1  decode holds a real instruction (0 = bubble)
- `gpr_a`, `gpr_b`, `gpr_c`  in  5 each  source GPR indices
- `read_gpr_a`, `read_gpr_b`, `read_gpr_c`  in  1 each  source actually read
- `write_gpr_dest_alu`  in  1  instruction writes `gpr_dest_alu` via ALU path
- `gpr_dest_alu`  in  5  ALU destination index
- `write_gpr_dest_mem`  in  1  instruction writes `gpr_dest_mem` via load path
- `gpr_dest_mem`  in  5  load destination index
- `read_ctr`, `read_lnk`, `read_cr`, `read_xer`  in  1 each  special-register reads
- `write_ctr`, `write_lnk`, `write_cr`, `write_xer`  in  1 each  special-register writes (ALU latency)
- `hold`  out  1  combinational; decode must not issue
- `issue`  out  1  `valid & !hold`
- `gpr_busy`  out  32  bit i = GPR i counter nonzero
- `stall_cycles`  out  16  saturating count of cycles with `valid & hold`

## Operation
- State: 32 GPR counters plus 4 special counters (CTR, LNK, CR, XER), each 4 bits wide; `stall_cycles`.
- RAW hazard:
  - A read flag is set and the corresponding counter is nonzero.
  - GPR reads compare `gpr_a/b/c` against their counters; special reads use their single counter.
- WAW hazard: a write flag is set and the destination counter exceeds the new write's latency. This prevents out-of-order writeback.
- `hold = valid & (any RAW | any WAW)`. `hold` is 0 when `valid = 0`.
- Per cycle, per counter:
  - If `issue` and the instruction writes this resource, the counter loads its latency: `ALU_LAT` for ALU-path and special writes, `MEM_LAT` for the load path.
  - Otherwise a nonzero counter decrements by 1.
  - A load dominates a decrement.
- Same index written by both paths in one instruction: the counter loads `MEM_LAT`, the maximum.
- No writes to GPR index collisions other than the above; index 0 is an ordinary register, not hardwired.
- `stall_cycles` increments when `valid & hold` and stops at 0xFFFF.
- No forwarding is modelled. The register file writes through, so the instruction may issue in the cycle its counter reads 0.

## Timing
- Reset values: all counters 0, `gpr_busy` = 0, `stall_cycles` = 0, `hold` = 0, `issue` = `valid`.
- Reset is asynchronous. Asserting it mid-stall clears every counter immediately and drops `hold` in the same cycle.
- `hold` and `issue` are combinational from inputs and counter state; there is no registered latency.
- Counter loaded at edge T (issue in cycle T-1) reads LAT in cycle T and 0 in cycle T+LAT.
  - A dependent reader waiting in decode is held for LAT cycles and issues in cycle T+LAT.
- Back-to-back independent instructions issue every cycle with zero hold.
- A held instruction must keep its descriptor stable. The scoreboard never loads counters while `hold` = 1.

## Test plan
- Reset, then `valid = 1` with no reads/writes: `hold` = 0, `issue` = 1 every cycle, `stall_cycles` stays 0.
- Issue an ALU write to r5, then an instruction reading r5 via `gpr_b` (`ALU_LAT` = 2): `hold` = 1 for exactly 2 cycles, `issue` on the 3rd, `stall_cycles` = 2.
- Load to r7 (`MEM_LAT` = 4), next instruction ALU-writes r7 and reads nothing: WAW `hold` lasts while counter > 2, i.e. 2 cycles; then it issues and r7's counter reloads to 2.
- One instruction with ALU dest r3 and mem dest r3: `gpr_busy[3]` is set for 4 cycles. A reader of r3 is held 4 cycles.
- `write_cr` issued, then `read_cr` with `valid` dropped for 1 cycle in between: `hold` = 1 for the remaining 1 cycle only. `hold` = 0 during the bubble.
- Assert `reset` while r9 is busy with `hold` = 1: `hold` falls asynchronously. After release, a reader of r9 issues immediately.
- Saturation: force 70000 held cycles via repeated RAW stalls; `stall_cycles` = 0xFFFF and does not wrap.

Source files
------------

// File: rtl/data_hazard_scoreboard.sv
// data_hazard_scoreboard
// Tracks in-flight GPR and special-register writes with per-resource
// countdowns. Raises a combinational decode hold on read-after-write or
// write-after-write conflicts, and counts the cycles spent stalled.
module data_hazard_scoreboard #(
  parameter int ALU_LAT = 2,  // issue-to-visible cycles, ALU path (1..7)
  parameter int MEM_LAT = 4   // issue-to-visible cycles, load path (ALU_LAT..15)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [4:0]  gpr_a,
  input  logic [4:0]  gpr_b,
  input  logic [4:0]  gpr_c,
  input  logic        read_gpr_a,
  input  logic        read_gpr_b,
  input  logic        read_gpr_c,
  input  logic        write_gpr_dest_alu,
  input  logic [4:0]  gpr_dest_alu,
  input  logic        write_gpr_dest_mem,
  input  logic [4:0]  gpr_dest_mem,
  input  logic        read_ctr,
  input  logic        read_lnk,
  input  logic        read_cr,
  input  logic        read_xer,
  input  logic        write_ctr,
  input  logic        write_lnk,
  input  logic        write_cr,
  input  logic        write_xer,
  output logic        hold,
  output logic        issue,
  output logic [31:0] gpr_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [3:0]  ALU_LAT_C = 4'(ALU_LAT);
  localparam logic [3:0]  MEM_LAT_C = 4'(MEM_LAT);
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Special-register slots in the special counter array.
  localparam int SPC_CTR = 0;
  localparam int SPC_LNK = 1;
  localparam int SPC_CR  = 2;
  localparam int SPC_XER = 3;

  // Next value of one countdown: a load wins over the decrement, and a
  // load-path write wins over an ALU-path write to the same resource
  // because MEM_LAT is never shorter than ALU_LAT.
  function automatic logic [3:0] next_count(input logic [3:0] cnt,
                                            input logic       load_alu,
                                            input logic       load_mem);
    logic [3:0] nxt;
    if (load_mem) begin
      nxt = MEM_LAT_C;
    end else if (load_alu) begin
      nxt = ALU_LAT_C;
    end else if (cnt != 4'd0) begin
      nxt = cnt - 4'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  logic [3:0]  gpr_cnt_r [32];
  logic [3:0]  spc_cnt_r [4];
  logic [3:0]  gpr_cnt_nxt_s [32];
  logic [3:0]  spc_cnt_nxt_s [4];
  logic [15:0] stall_r;

  logic        raw_gpr_s;
  logic        raw_spc_s;
  logic        waw_gpr_s;
  logic        waw_spc_s;
  logic        hold_s;
  logic        issue_s;
  logic [3:0]  spc_read_s;
  logic [3:0]  spc_write_s;

  assign spc_read_s  = {read_xer, read_cr, read_lnk, read_ctr};
  assign spc_write_s = {write_xer, write_cr, write_lnk, write_ctr};

  // Hazard detection: RAW on any nonzero source counter, WAW when an older
  // write would retire after the new one.
  always_comb begin
    raw_gpr_s = 1'b0;
    raw_spc_s = 1'b0;
    waw_gpr_s = 1'b0;
    waw_spc_s = 1'b0;
    if (read_gpr_a && (gpr_cnt_r[gpr_a] != 4'd0)) begin
      raw_gpr_s = 1'b1;
    end else begin
      raw_gpr_s = raw_gpr_s;
    end
    if (read_gpr_b && (gpr_cnt_r[gpr_b] != 4'd0)) begin
      raw_gpr_s = 1'b1;
    end else begin
      raw_gpr_s = raw_gpr_s;
    end
    if (read_gpr_c && (gpr_cnt_r[gpr_c] != 4'd0)) begin
      raw_gpr_s = 1'b1;
    end else begin
      raw_gpr_s = raw_gpr_s;
    end
    if (write_gpr_dest_alu && (gpr_cnt_r[gpr_dest_alu] > ALU_LAT_C)) begin
      waw_gpr_s = 1'b1;
    end else begin
      waw_gpr_s = waw_gpr_s;
    end
    if (write_gpr_dest_mem && (gpr_cnt_r[gpr_dest_mem] > MEM_LAT_C)) begin
      waw_gpr_s = 1'b1;
    end else begin
      waw_gpr_s = waw_gpr_s;
    end
    for (int s = 0; s < 4; s++) begin
      if (spc_read_s[s] && (spc_cnt_r[s] != 4'd0)) begin
        raw_spc_s = 1'b1;
      end else begin
        raw_spc_s = raw_spc_s;
      end
      if (spc_write_s[s] && (spc_cnt_r[s] > ALU_LAT_C)) begin
        waw_spc_s = 1'b1;
      end else begin
        waw_spc_s = waw_spc_s;
      end
    end
    hold_s  = valid & (raw_gpr_s | raw_spc_s | waw_gpr_s | waw_spc_s);
    issue_s = valid & ~hold_s;
  end

  // Next counter values; loads only happen on a real issue.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      gpr_cnt_nxt_s[i] = next_count(gpr_cnt_r[i],
                                    issue_s && write_gpr_dest_alu && (gpr_dest_alu == 5'(i)),
                                    issue_s && write_gpr_dest_mem && (gpr_dest_mem == 5'(i)));
    end
    for (int s = 0; s < 4; s++) begin
      spc_cnt_nxt_s[s] = next_count(spc_cnt_r[s], issue_s && spc_write_s[s], 1'b0);
    end
  end

  // Counter state; asynchronous reset clears every in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_cnt_r[i] <= 4'd0;
      end
      for (int s = 0; s < 4; s++) begin
        spc_cnt_r[s] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        gpr_cnt_r[i] <= gpr_cnt_nxt_s[i];
      end
      for (int s = 0; s < 4; s++) begin
        spc_cnt_r[s] <= spc_cnt_nxt_s[s];
      end
    end
  end

  // Saturating count of cycles where a real instruction was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_r <= 16'd0;
    end else if (hold_s && (stall_r != STALL_MAX)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  // Busy vector straight from the registered counters.
  always_comb begin
    gpr_busy = 32'd0;
    for (int i = 0; i < 32; i++) begin
      gpr_busy[i] = (gpr_cnt_r[i] != 4'd0);
    end
  end

  assign hold         = hold_s;
  assign issue        = issue_s;
  assign stall_cycles = stall_r;

  // Slot names kept for readability of the packed special vectors.
  logic [1:0] spc_slot_unused_s;
  assign spc_slot_unused_s = 2'(SPC_CTR + SPC_LNK + SPC_CR + SPC_XER);

endmodule

// File: tb/tb_data_hazard_scoreboard.sv
// Directed self-checking bench for data_hazard_scoreboard (default latencies).
module tb_data_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [4:0]  gpr_a, gpr_b, gpr_c;
  logic        read_gpr_a, read_gpr_b, read_gpr_c;
  logic        write_gpr_dest_alu;
  logic [4:0]  gpr_dest_alu;
  logic        write_gpr_dest_mem;
  logic [4:0]  gpr_dest_mem;
  logic        read_ctr, read_lnk, read_cr, read_xer;
  logic        write_ctr, write_lnk, write_cr, write_xer;
  logic        hold, issue;
  logic [31:0] gpr_busy;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_stall = 0;

  data_hazard_scoreboard dut (
    .clk(clk), .reset(reset), .valid(valid),
    .gpr_a(gpr_a), .gpr_b(gpr_b), .gpr_c(gpr_c),
    .read_gpr_a(read_gpr_a), .read_gpr_b(read_gpr_b), .read_gpr_c(read_gpr_c),
    .write_gpr_dest_alu(write_gpr_dest_alu), .gpr_dest_alu(gpr_dest_alu),
    .write_gpr_dest_mem(write_gpr_dest_mem), .gpr_dest_mem(gpr_dest_mem),
    .read_ctr(read_ctr), .read_lnk(read_lnk), .read_cr(read_cr), .read_xer(read_xer),
    .write_ctr(write_ctr), .write_lnk(write_lnk), .write_cr(write_cr), .write_xer(write_xer),
    .hold(hold), .issue(issue), .gpr_busy(gpr_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_desc();
    gpr_a = 5'd0; gpr_b = 5'd0; gpr_c = 5'd0;
    read_gpr_a = 1'b0; read_gpr_b = 1'b0; read_gpr_c = 1'b0;
    write_gpr_dest_alu = 1'b0; gpr_dest_alu = 5'd0;
    write_gpr_dest_mem = 1'b0; gpr_dest_mem = 5'd0;
    read_ctr = 1'b0; read_lnk = 1'b0; read_cr = 1'b0; read_xer = 1'b0;
    write_ctr = 1'b0; write_lnk = 1'b0; write_cr = 1'b0; write_xer = 1'b0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check hold/issue of the current cycle after inputs settle.
  task automatic check_hi(input string tag, input logic exp_hold, input logic exp_issue);
    #1;
    check_value({tag, ".hold"}, {31'd0, hold}, {31'd0, exp_hold});
    check_value({tag, ".issue"}, {31'd0, issue}, {31'd0, exp_issue});
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b1;
    clear_desc();
    tick();
    tick();
    // Reset state while reset is still asserted.
    check_hi("rst", 1'b0, 1'b1);
    check_value("rst.busy", gpr_busy, 32'd0);
    check_value("rst.stall", {16'd0, stall_cycles}, 32'd0);
    reset = 1'b0;
    tick();

    // 1) Independent instructions: no hold, issue every cycle.
    for (int k = 0; k < 4; k++) begin
      check_hi("idle", 1'b0, 1'b1);
      tick();
    end
    check_value("idle.stall", {16'd0, stall_cycles}, 32'd0);

    // 2) ALU write r5, then reader via gpr_b: held 2 cycles.
    write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd5;
    check_hi("raw.wr", 1'b0, 1'b1);
    tick();
    clear_desc(); read_gpr_b = 1'b1; gpr_b = 5'd5;
    check_hi("raw.h1", 1'b1, 1'b0);
    check_value("raw.busy5", {31'd0, gpr_busy[5]}, 32'd1);
    tick();
    check_hi("raw.h2", 1'b1, 1'b0);
    tick();
    check_hi("raw.go", 1'b0, 1'b1);
    exp_stall = 2;
    check_value("raw.stall", {16'd0, stall_cycles}, exp_stall);
    tick();
    clear_desc(); valid = 1'b0;
    tick();

    // 3) Load r7, then ALU write r7: WAW held 2 cycles, then reloads to 2.
    valid = 1'b1; write_gpr_dest_mem = 1'b1; gpr_dest_mem = 5'd7;
    check_hi("waw.ld", 1'b0, 1'b1);
    tick();
    clear_desc(); write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd7;
    check_hi("waw.h1", 1'b1, 1'b0);
    tick();
    check_hi("waw.h2", 1'b1, 1'b0);
    tick();
    check_hi("waw.go", 1'b0, 1'b1);
    tick();
    clear_desc(); valid = 1'b0;
    check_value("waw.busy7a", {31'd0, gpr_busy[7]}, 32'd1);
    tick();
    check_value("waw.busy7b", {31'd0, gpr_busy[7]}, 32'd1);
    tick();
    check_value("waw.busy7c", {31'd0, gpr_busy[7]}, 32'd0);
    exp_stall += 2;
    check_value("waw.stall", {16'd0, stall_cycles}, exp_stall);

    // 4) Dual-path write to r3: MEM_LAT wins, reader held 4 cycles.
    valid = 1'b1;
    write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd3;
    write_gpr_dest_mem = 1'b1; gpr_dest_mem = 5'd3;
    check_hi("dual.wr", 1'b0, 1'b1);
    tick();
    clear_desc(); read_gpr_c = 1'b1; gpr_c = 5'd3;
    for (int k = 0; k < 4; k++) begin
      check_hi("dual.h", 1'b1, 1'b0);
      check_value("dual.busy3", {31'd0, gpr_busy[3]}, 32'd1);
      tick();
    end
    check_hi("dual.go", 1'b0, 1'b1);
    check_value("dual.busy3off", {31'd0, gpr_busy[3]}, 32'd0);
    exp_stall += 4;
    tick();
    clear_desc();

    // 5) write_cr, one bubble, then read_cr: held only the remaining cycle.
    write_cr = 1'b1;
    check_hi("cr.wr", 1'b0, 1'b1);
    tick();
    clear_desc(); read_cr = 1'b1; valid = 1'b0;
    check_hi("cr.bub", 1'b0, 1'b0);
    tick();
    valid = 1'b1;
    check_hi("cr.h1", 1'b1, 1'b0);
    tick();
    check_hi("cr.go", 1'b0, 1'b1);
    exp_stall += 1;
    check_value("cr.stall", {16'd0, stall_cycles}, exp_stall);
    tick();
    clear_desc();

    // 6) Asynchronous reset mid-stall on r9.
    write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd9;
    tick();
    clear_desc(); read_gpr_a = 1'b1; gpr_a = 5'd9;
    check_hi("ar.h", 1'b1, 1'b0);
    reset = 1'b1;
    check_hi("ar.rst", 1'b0, 1'b1);
    check_value("ar.busy", gpr_busy, 32'd0);
    check_value("ar.stall", {16'd0, stall_cycles}, 32'd0);
    #1;
    reset = 1'b0;
    check_hi("ar.go", 1'b0, 1'b1);
    tick();
    clear_desc();

    // 7) Saturation: self-repeating read+load of r1 gives 4 stalls per 5 cycles.
    read_gpr_a = 1'b1; gpr_a = 5'd1;
    write_gpr_dest_mem = 1'b1; gpr_dest_mem = 5'd1;
    for (int k = 0; k < 5000; k++) tick();
    check_value("sat.mid", {16'd0, stall_cycles}, 32'd4000);
    for (int k = 0; k < 83000; k++) tick();
    check_value("sat.max", {16'd0, stall_cycles}, 32'h0000FFFF);
    for (int k = 0; k < 10; k++) tick();
    check_value("sat.hold", {16'd0, stall_cycles}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
